aespim_op_sequencer: RTL and testbench

//  Upstream command sequencer for the AES/GF PIM accelerator datapath. Accepts one

---
 rtl/aespim_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_aespim_op_sequencer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aespim_op_sequencer.sv
// Upstream command sequencer for the AES/GF PIM accelerator datapath.
// Expands one word-block command (load, store, key-expansion step, encrypt
// round) into four per-column beats. Each beat handshakes with the memory
// port and pulses the accelerator start with the matching {shift-row, op}
// code, so the core never has to hand-issue column opcodes.
module aespim_op_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_type_i,
  input  logic [31:0] cmd_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  output logic        acc_start_o,
  output logic [5:0]  acc_op_code_o,
  input  logic [31:0] acc_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // Accelerator op codes
  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_ST   = 3'd1;
  localparam logic [2:0] OP_KEXI = 3'd2;
  localparam logic [2:0] OP_KEX  = 3'd3;
  localparam logic [2:0] OP_ENCI = 3'd4;
  localparam logic [2:0] OP_ENCM = 3'd5;
  localparam logic [2:0] OP_ENCF = 3'd6;

  // Command types; anything above CMD_ENC_FINAL is illegal
  localparam logic [2:0] CMD_LOAD      = 3'd0;
  localparam logic [2:0] CMD_STORE     = 3'd1;
  localparam logic [2:0] CMD_KEX       = 3'd2;
  localparam logic [2:0] CMD_ENC_INIT  = 3'd3;
  localparam logic [2:0] CMD_ENC_MID   = 3'd4;
  localparam logic [2:0] CMD_ENC_FINAL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic [2:0]  op_sel;
  logic [2:0]  sr_amt;

  // Write data passes straight through from the accelerator output
  assign mem_wdata_o = acc_data_i;

  // State register plus latched command fields
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      type_q  <= 3'd0;
      addr_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Per-beat opcode: encrypt rounds use the beat index as shift-row amount
  always_comb begin
    op_sel = OP_LD;
    sr_amt = 3'd0;
    case (type_q)
      CMD_LOAD:      op_sel = OP_LD;
      CMD_STORE:     op_sel = OP_ST;
      CMD_KEX:       op_sel = (beat_q == 2'd0) ? OP_KEXI : OP_KEX;
      CMD_ENC_INIT:  begin op_sel = OP_ENCI; sr_amt = {1'b0, beat_q}; end
      CMD_ENC_MID:   begin op_sel = OP_ENCM; sr_amt = {1'b0, beat_q}; end
      CMD_ENC_FINAL: begin op_sel = OP_ENCF; sr_amt = {1'b0, beat_q}; end
      default:       begin op_sel = OP_LD;   sr_amt = 3'd0; end
    endcase
  end

  // Next-state and output decode for IDLE / RUN / DONE
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    type_d        = type_q;
    addr_d        = addr_q;
    err_d         = err_q;
    cmd_ready_o   = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = 32'd0;
    acc_start_o   = 1'b0;
    acc_op_code_o = 6'd0;
    busy_o        = (state_q != ST_IDLE);
    done_o        = 1'b0;
    err_o         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          type_d = cmd_type_i;
          addr_d = cmd_addr_i & 32'hFFFF_FFFC;
          beat_d = 2'd0;
          if (cmd_type_i > CMD_ENC_FINAL) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        mem_req_o     = 1'b1;
        mem_we_o      = (type_q == CMD_STORE);
        mem_addr_o    = addr_q + {28'd0, beat_q, 2'b00};
        acc_op_code_o = {sr_amt, op_sel};
        acc_start_o   = mem_ack_i;
        if (mem_ack_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aespim_op_sequencer.sv
// Self-checking bench for aespim_op_sequencer: expected beats are queued
// when a command is issued and checked as the sequencer emits starts.
module tb_aespim_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_type = 3'd0;
  logic [31:0] cmd_addr = 32'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        acc_start;
  logic [5:0]  acc_op;
  logic [31:0] acc_data = 32'd0;
  logic        busy;
  logic        done;
  logic        err;

  aespim_op_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_type_i    (cmd_type),
    .cmd_addr_i    (cmd_addr),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_ack_i     (mem_ack),
    .acc_start_o   (acc_start),
    .acc_op_code_o (acc_op),
    .acc_data_i    (acc_data),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [5:0]  op;
    logic [31:0] wdata;
  } beat_t;

  beat_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;
  logic prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  // Cycle index, stable for the whole period after each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Expected {shift-row, op} for command type t at beat b
  function automatic logic [5:0] exp_op(input logic [2:0] t, input logic [1:0] b);
    case (t)
      3'd0:    return {3'd0, 3'd0};
      3'd1:    return {3'd0, 3'd1};
      3'd2:    return (b == 2'd0) ? {3'd0, 3'd2} : {3'd0, 3'd3};
      3'd3:    return {1'b0, b, 3'd4};
      3'd4:    return {1'b0, b, 3'd5};
      3'd5:    return {1'b0, b, 3'd6};
      default: return 6'd0;
    endcase
  endfunction

  // Scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      checks++;
      if (acc_start !== (mem_req && mem_ack)) begin
        errors++;
        $display("[TB] FAIL start_gating: start=%b req=%b ack=%b (start must equal req&ack)", acc_start, mem_req, mem_ack);
      end
      if (prev_wait) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
          errors++;
          $display("[TB] FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, prev_addr);
        end
      end
      if (busy) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ready_busy: cmd_ready=%b, required 0 while busy", cmd_ready);
        end
      end else begin
        checks++;
        if (acc_op !== 6'd0 || mem_req !== 1'b0 || cmd_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL idle_outputs: op=%h req=%b ready=%b, required 00/0/1", acc_op, mem_req, cmd_ready);
        end
      end
      if (mem_req) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_req: req at addr %h with no beat expected", mem_addr);
        end else if (mem_addr !== sb[0].addr || mem_we !== sb[0].we || acc_op !== sb[0].op) begin
          errors++;
          $display("[TB] FAIL beat: addr=%h we=%b op=%h, required addr=%h we=%b op=%h",
                   mem_addr, mem_we, acc_op, sb[0].addr, sb[0].we, sb[0].op);
        end
      end
      if (acc_start && sb.size() > 0) begin
        if (sb[0].we) begin
          checks++;
          if (mem_wdata !== sb[0].wdata) begin
            errors++;
            $display("[TB] FAIL wdata: got %h, required %h", mem_wdata, sb[0].wdata);
          end
        end
        void'(sb.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
      end
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
    end
  end

  // Issues one command and acks nbeats beats, each after 'waits' idle cycles.
  // poke keeps cmd_valid high with a different command while busy.
  task automatic run_cmd(input logic [2:0] t, input logic [31:0] a, input int waits,
                         input int nbeats, input bit poke, output int t_acc);
    logic [31:0] base;
    base = a & 32'hFFFF_FFFC;
    if (t <= 3'd5) begin
      for (int b = 0; b < 4; b++) begin
        beat_t e;
        e.addr  = base + 32'(b * 4);
        e.we    = (t == 3'd1);
        e.op    = exp_op(t, 2'(b));
        e.wdata = acc_data;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_addr  = a;
    t_acc = -1;
    for (int k = 0; k < 20 && t_acc < 0; k++) begin
      @(negedge clk);
      if (cmd_ready) t_acc = cyc;
      @(posedge clk); #1;
    end
    cmd_valid = poke;
    if (poke) begin
      cmd_type = 3'd1;
      cmd_addr = 32'h0000_ABC0;
    end
    if (t_acc >= 0) begin
      for (int b = 0; b < nbeats; b++) begin
        repeat (waits) begin @(posedge clk); #1; end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for the monitor to see a new done pulse
  task automatic wait_done(input int prev, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #1;
      if (done_cnt > prev) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    int t;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, mem_req, acc_start, done, err, busy, acc_op} !== {6'b100000, 6'd0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got %b, required %b",
               {cmd_ready, mem_req, acc_start, done, err, busy, acc_op}, {6'b100000, 6'd0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(3'd4, 32'h0000_0040, 0, 1, 1'b0, t);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, mem_req, acc_start, done, err, busy, acc_op} !== {6'b100000, 6'd0}) begin
      errors++;
      $display("[TB] FAIL reset_midclock: got %b, required %b",
               {cmd_ready, mem_req, acc_start, done, err, busy, acc_op}, {6'b100000, 6'd0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_load();
    int t;
    int prev;
    bit got;
    acc_data = $urandom;
    prev = done_cnt;
    run_cmd(3'd0, 32'h0000_0100, 0, 4, 1'b0, t);
    wait_done(prev, got);
    checks++;
    if (!got || done_cyc != t + 5 || done_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done: got=%0d at T+%0d err=%b, required done at T+5 err=0", got, done_cyc - t, done_err);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL load_beats: %0d beats outstanding, required 0", sb.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_after: done=%b ready=%b at T+6, required 0/1", done, cmd_ready);
    end
  endtask

  task automatic test_enc_mid();
    int t;
    int prev;
    bit got;
    prev = done_cnt;
    run_cmd(3'd4, 32'h0000_0200, 2, 4, 1'b0, t);
    wait_done(prev, got);
    checks++;
    if (!got || done_cyc != t + 13 || done_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL encmid_done: got=%0d at T+%0d err=%b, required done at T+13 err=0", got, done_cyc - t, done_err);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL encmid_beats: %0d beats outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_store_kex();
    int t;
    int prev;
    bit got;
    acc_data = 32'hDEAD_BEEF;
    prev = done_cnt;
    run_cmd(3'd1, 32'h0000_0303, 0, 4, 1'b0, t);
    wait_done(prev, got);
    checks++;
    if (!got || done_cyc != t + 5 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL store_done: got=%0d at T+%0d left=%0d, required done at T+5 left=0", got, done_cyc - t, sb.size());
    end
    acc_data = 32'h1234_5678;
    prev = done_cnt;
    run_cmd(3'd2, 32'h0000_0400, 1, 4, 1'b0, t);
    wait_done(prev, got);
    checks++;
    if (!got || done_cyc != t + 9 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL kex_done: got=%0d at T+%0d left=%0d, required done at T+9 left=0", got, done_cyc - t, sb.size());
    end
  endtask

  task automatic test_illegal();
    int t;
    int prev;
    bit got;
    for (int i = 0; i < 2; i++) begin
      logic [2:0] bad;
      bad = (i == 0) ? 3'd7 : 3'd6;
      prev = done_cnt;
      run_cmd(bad, 32'h0000_0500, 0, 0, 1'b0, t);
      wait_done(prev, got);
      checks++;
      if (!got || done_cyc != t + 1 || done_err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL illegal_done: type=%0d got=%0d at T+%0d err=%b, required done at T+1 err=1", bad, got, done_cyc - t, done_err);
      end
    end
    prev = done_cnt;
    run_cmd(3'd0, 32'h0000_0600, 0, 4, 1'b0, t);
    wait_done(prev, got);
    checks++;
    if (!got || done_cyc != t + 5 || done_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_illegal: got=%0d at T+%0d err=%b, required done at T+5 err=0", got, done_cyc - t, done_err);
    end
  endtask

  task automatic test_reset_mid_beat2();
    int t;
    int prev;
    bit got;
    run_cmd(3'd0, 32'h0000_0700, 0, 2, 1'b0, t);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, mem_req, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_beat2: busy/req/done=%b, required 000", {busy, mem_req, done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    prev = done_cnt;
    repeat (8) @(negedge clk);
    checks++;
    if (done_cnt != prev || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: %0d done pulses busy=%b, required 0 pulses busy=0", done_cnt - prev, busy);
    end
    prev = done_cnt;
    run_cmd(3'd0, 32'h0000_0800, 0, 4, 1'b0, t);
    wait_done(prev, got);
    checks++;
    if (!got || done_cyc != t + 5 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_cmd: got=%0d at T+%0d left=%0d, required done at T+5 left=0", got, done_cyc - t, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int prev;
    bit got;
    prev = done_cnt;
    run_cmd(3'd3, 32'h0000_0900, 0, 4, 1'b1, t);
    wait_done(prev, got);
    checks++;
    if (!got || done_cyc != t + 5 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL busy_poke: got=%0d at T+%0d left=%0d, required done at T+5 left=0", got, done_cyc - t, sb.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != prev + 1) begin
      errors++;
      $display("[TB] FAIL busy_queued: busy=%b pulses=%0d, required 0 and 1", busy, done_cnt - prev);
    end
  endtask

  task automatic test_stray_ack();
    @(posedge clk); #1;
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (acc_start !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stray_ack: start=%b busy=%b, required 0/0", acc_start, busy);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    int t;
    int prev;
    bit got;
    prev = done_cnt;
    run_cmd(3'd5, 32'hFFFF_FFF8, 1, 4, 1'b0, t);
    wait_done(prev, got);
    checks++;
    if (!got || done_cyc != t + 9 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL wrap_done: got=%0d at T+%0d left=%0d, required done at T+9 left=0", got, done_cyc - t, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_enc_mid();
    test_store_kex();
    test_illegal();
    test_reset_mid_beat2();
    test_back_to_back();
    test_stray_ack();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
